// File: rtl/onehot_mux_arbiter_if.sv
// Requester/output bundle of the round-robin one-hot mux arbiter.
// The arbiter takes the slave modport; the requester/sink side takes master.
interface onehot_mux_arbiter_if #(
   parameter int N = 4,
   parameter int W = 2
);
   logic [N-1:0]   req;
   logic [N*W-1:0] idata;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [W-1:0]   odata;
   logic           ovalid;
   logic           oready;

   modport master (output req, idata, oready, input gnt, ack, odata, ovalid);
   modport slave  (input req, idata, oready, output gnt, ack, odata, ovalid);
endinterface

// File: rtl/onehot_mux_arbiter.sv
// Rotating-priority arbiter driving a one-hot AND-OR mux onto one valid/ready port.
// Optional burst lock input is compiled in with RR_ARB_LOCK_EN.
module onehot_mux_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input logic                 clk,
   input logic                 rst_n,
`ifdef RR_ARB_LOCK_EN
   input logic                 lock,
`endif
   onehot_mux_arbiter_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam logic [N-1:0] PTR_RST = N'(1'b1);

   state_e       state_q, state_d;
   logic [N-1:0] ptr_q, ptr_d;
   logic [N-1:0] gnt_q, gnt_d;
   logic         ovalid_q, ovalid_d;

   logic [N-1:0] idle_win_s;
   logic [N-1:0] rot_s;
   logic [N-1:0] busy_win_s;
   logic         grantee_req_s;
   logic         hold_burst_s;
   logic [N-1:0] ack_s;
   logic [W-1:0] odata_s;

   // Circular scan starting at the one-hot pointer; the result is one-hot or zero
   // even if the pointer were ever corrupted.
   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [N-1:0] p);
      logic [N-1:0] g;
      logic         armed;
      logic         found;
      g     = '0;
      armed = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 2 * N; k++) begin
         if (p[k % N]) begin
            armed = 1'b1;
         end
         if (armed && !found && r[k % N]) begin
            g[k % N] = 1'b1;
            found    = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
      logic [N-1:0] o;
      o = '0;
      for (int i = 0; i < N; i++) begin
         o[(i + 1) % N] = v[i];
      end
      return o;
   endfunction

   // Candidate winners for the idle and the re-arbitrate-after-transfer cases
   always_comb begin
      idle_win_s    = rr_pick(bus.req, ptr_q);
      rot_s         = rotl1(gnt_q);
      busy_win_s    = rr_pick(bus.req & ~gnt_q, rot_s);
      grantee_req_s = |(bus.req & gnt_q);
`ifdef RR_ARB_LOCK_EN
      hold_burst_s  = lock & grantee_req_s;
`else
      hold_burst_s  = 1'b0;
`endif
   end

   // Next-state sequencing of grant, pointer and valid
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      ovalid_d = ovalid_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               gnt_d    = idle_win_s;
               ovalid_d = 1'b1;
               state_d  = BUSY;
            end else begin
               gnt_d    = '0;
               ovalid_d = 1'b0;
            end
         end
         BUSY: begin
            if (bus.oready) begin
               if (hold_burst_s) begin
                  gnt_d = gnt_q;
               end else begin
                  ptr_d = rot_s;
                  if (|busy_win_s) begin
                     gnt_d    = busy_win_s;
                     ovalid_d = 1'b1;
                  end else begin
                     gnt_d    = '0;
                     ovalid_d = 1'b0;
                     state_d  = IDLE;
                  end
               end
            end else if (!grantee_req_s) begin
               // grantee withdrew before being accepted: drop the word, keep priority
               gnt_d    = '0;
               ovalid_d = 1'b0;
               state_d  = IDLE;
            end else begin
               gnt_d = gnt_q;
            end
         end
         default: begin
            state_d  = IDLE;
            ptr_d    = PTR_RST;
            gnt_d    = '0;
            ovalid_d = 1'b0;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= PTR_RST;
         gnt_q    <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         ovalid_q <= ovalid_d;
      end
   end

   // Acknowledge and one-hot AND-OR data mux
   always_comb begin
      if (state_q == BUSY) begin
         ack_s = gnt_q & {N{bus.oready}};
      end else begin
         ack_s = '0;
      end
      odata_s = '0;
      for (int i = 0; i < N; i++) begin
         odata_s = odata_s | (bus.idata[i*W +: W] & {W{gnt_q[i]}});
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.ovalid = ovalid_q;
   assign bus.ack    = ack_s;
   assign bus.odata  = odata_s;

endmodule

// File: tb/tb_onehot_mux_arbiter.sv
// Directed bench for onehot_mux_arbiter (N=4, W=2); lock test runs when RR_ARB_LOCK_EN is defined.
module tb_onehot_mux_arbiter;
   localparam int N = 4;
   localparam int W = 2;

   logic clk;
   logic rst_n;
`ifdef RR_ARB_LOCK_EN
   logic lock;
`endif
   int checks = 0;
   int errors = 0;

   onehot_mux_arbiter_if #(.N(N), .W(W)) bus ();

   onehot_mux_arbiter #(.N(N), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef RR_ARB_LOCK_EN
      .lock  (lock),
`endif
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n      = 1'b1;
      bus.req    = 4'b1111;
      bus.idata  = 8'b11_10_01_00;
      bus.oready = 1'b1;
`ifdef RR_ARB_LOCK_EN
      lock       = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b want %b", bus.gnt, 4'b0000); end
      checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL rst_ovalid got %b want %b", bus.ovalid, 1'b0); end
      checks++; if (bus.odata !== 2'b00) begin errors++; $display("FAIL rst_odata got %b want %b", bus.odata, 2'b00); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got %b want %b", bus.ack, 4'b0000); end
      tick();
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rst_held_gnt got %b want %b", bus.gnt, 4'b0000); end
      rst_n = 1'b1;
      tick();
      checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt got %b want %b", bus.gnt, 4'b0001); end
      checks++; if (bus.ovalid !== 1'b1) begin errors++; $display("FAIL first_ovalid got %b want %b", bus.ovalid, 1'b1); end
      checks++; if (bus.odata !== 2'b00) begin errors++; $display("FAIL first_odata got %b want %b", bus.odata, 2'b00); end
   endtask

   task automatic test_full_contention;
      logic [3:0] exp_g [4];
      logic [1:0] exp_d [4];
      exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_d = '{2'b01, 2'b10, 2'b11, 2'b00};
      checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL fc_ack0 got %b want %b", bus.ack, 4'b0001); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (bus.gnt !== exp_g[i]) begin errors++; $display("FAIL fc_gnt[%0d] got %b want %b", i, bus.gnt, exp_g[i]); end
         checks++; if (bus.odata !== exp_d[i]) begin errors++; $display("FAIL fc_odata[%0d] got %b want %b", i, bus.odata, exp_d[i]); end
         checks++; if (bus.ovalid !== 1'b1) begin errors++; $display("FAIL fc_ovalid[%0d] got %b want %b", i, bus.ovalid, 1'b1); end
         checks++; if (bus.ack !== exp_g[i]) begin errors++; $display("FAIL fc_ack[%0d] got %b want %b", i, bus.ack, exp_g[i]); end
      end
      bus.req = 4'b0001;
      tick();
      bus.req = 4'b0000;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL fc_drain_gnt got %b want %b", bus.gnt, 4'b0000); end
      checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL fc_drain_ovalid got %b want %b", bus.ovalid, 1'b0); end
   endtask

   task automatic test_backpressure;
      bus.req    = 4'b0100;
      bus.oready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL bp_gnt[%0d] got %b want %b", i, bus.gnt, 4'b0100); end
         checks++; if (bus.odata !== 2'b10) begin errors++; $display("FAIL bp_odata[%0d] got %b want %b", i, bus.odata, 2'b10); end
         checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL bp_ack[%0d] got %b want %b", i, bus.ack, 4'b0000); end
      end
      bus.oready = 1'b1;
      #1;
      checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL bp_ack_release got %b want %b", bus.ack, 4'b0100); end
      tick();
      bus.req = 4'b0000;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL bp_idle_gnt got %b want %b", bus.gnt, 4'b0000); end
      checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL bp_idle_ovalid got %b want %b", bus.ovalid, 1'b0); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL bp_idle_ack got %b want %b", bus.ack, 4'b0000); end
   endtask

   task automatic test_fairness;
      bus.req = 4'b0010;
      tick();
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL fair_gnt1 got %b want %b", bus.gnt, 4'b0010); end
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL fair_idle1 got %b want %b", bus.gnt, 4'b0000); end
      bus.req = 4'b0011;
      tick();
      checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL fair_gnt0 got %b want %b", bus.gnt, 4'b0001); end
      tick();
      bus.req = 4'b0010;
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL fair_b2b_gnt got %b want %b", bus.gnt, 4'b0010); end
      checks++; if (bus.odata !== 2'b01) begin errors++; $display("FAIL fair_b2b_odata got %b want %b", bus.odata, 2'b01); end
      tick();
      bus.req = 4'b0000;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL fair_idle2 got %b want %b", bus.gnt, 4'b0000); end
      // pointer now at 2: requesters 0 and 3 pending must go to 3 first
      bus.req    = 4'b1001;
      bus.oready = 1'b0;
      tick();
      checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL fair_gnt3 got %b want %b", bus.gnt, 4'b1000); end
      checks++; if (bus.odata !== 2'b11) begin errors++; $display("FAIL fair_odata3 got %b want %b", bus.odata, 2'b11); end
   endtask

   task automatic test_violation_and_reset;
      bus.req = 4'b0001;
      #1;
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL vio_ack got %b want %b", bus.ack, 4'b0000); end
      tick();
      bus.req = 4'b0110;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL vio_gnt got %b want %b", bus.gnt, 4'b0000); end
      checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL vio_ovalid got %b want %b", bus.ovalid, 1'b0); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL vio_ack_after got %b want %b", bus.ack, 4'b0000); end
      tick();
      checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL vio_ptr_kept got %b want %b", bus.gnt, 4'b0100); end
      bus.oready = 1'b1;
      tick();
      bus.req = 4'b0010;
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL vio_next_gnt got %b want %b", bus.gnt, 4'b0010); end
      bus.oready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got %b want %b", bus.gnt, 4'b0000); end
      checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL midrst_ovalid got %b want %b", bus.ovalid, 1'b0); end
      checks++; if (bus.odata !== 2'b00) begin errors++; $display("FAIL midrst_odata got %b want %b", bus.odata, 2'b00); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL midrst_ack got %b want %b", bus.ack, 4'b0000); end
      bus.req = 4'b1010;
      rst_n   = 1'b1;
      tick();
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_regnt got %b want %b", bus.gnt, 4'b0010); end
      bus.oready = 1'b1;
      tick();
      bus.req = 4'b1000;
      checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL midrst_gnt3 got %b want %b", bus.gnt, 4'b1000); end
      tick();
      bus.req = 4'b0000;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL midrst_idle got %b want %b", bus.gnt, 4'b0000); end
   endtask

`ifdef RR_ARB_LOCK_EN
   task automatic test_lock;
      bus.req    = 4'b0011;
      bus.oready = 1'b1;
      lock       = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL lock_gnt[%0d] got %b want %b", i, bus.gnt, 4'b0001); end
         checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL lock_ack[%0d] got %b want %b", i, bus.ack, 4'b0001); end
         if (i == 2) begin
            lock = 1'b0;
         end
         tick();
      end
      bus.req = 4'b0010;
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL lock_release_gnt got %b want %b", bus.gnt, 4'b0010); end
      tick();
      bus.req = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_full_contention();
      test_backpressure();
      test_fairness();
      test_violation_and_reset();
`ifdef RR_ARB_LOCK_EN
      test_lock();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
